// File: rtl/dcim_resp_checker_if.sv
// ----------------------------------------------------------------------------
// dcim_resp_checker_if
// Bundles the two streams seen by the response checker:
//   expected stream : exp_valid/exp_ready handshake carrying {data, flag, mask, last}
//   observed stream : obs_valid qualifying a DCIM output sample (nout/st)
// Modports:
//   master : the agent supplying expected words and observed samples
//   slave  : the checker (drives exp_ready only)
// ----------------------------------------------------------------------------
interface dcim_resp_checker_if #(
   parameter int DW = 51,
   parameter int FW = 1
);
   logic          exp_valid;
   logic          exp_ready;
   logic [DW-1:0] exp_data;
   logic [FW-1:0] exp_flag;
   logic [DW-1:0] exp_mask;
   logic          exp_last;
   logic          obs_valid;
   logic [DW-1:0] obs_data;
   logic [FW-1:0] obs_flag;

   modport master (
      output exp_valid, exp_data, exp_flag, exp_mask, exp_last,
      output obs_valid, obs_data, obs_flag,
      input  exp_ready
   );

   modport slave (
      input  exp_valid, exp_data, exp_flag, exp_mask, exp_last,
      input  obs_valid, obs_data, obs_flag,
      output exp_ready
   );
endinterface

// File: rtl/dcim_resp_checker.sv
// ----------------------------------------------------------------------------
// dcim_resp_checker
// Response checker for the DCIM macro output stream. Expected words are queued
// in a FIFO; every observed sample in RUN pops one word and is compared under
// a per-bit data mask (the flag is always compared). Keeps saturating error and
// compare counters, a sticky underflow flag, and captures the first failure.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   clr                  synchronous flush of FIFO, stats and FSM
//   arm                  leave IDLE and start checking
//   bus (slave)          expected-word push port and observed-sample port
//   mismatch             1-cycle pulse per failing compare (1 cycle latency)
//   err_cnt, cmp_cnt     saturating failure / compare counters
//   first_err_idx/obs/exp  compare index and data of the first failure
//   underflow            sticky: a sample arrived with the FIFO empty
//   done, pass           check finished / finished without any failure
// ----------------------------------------------------------------------------
module dcim_resp_checker #(
   parameter int DW    = 51,
   parameter int FW    = 1,
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             arm,
   dcim_resp_checker_if.slave bus,
   output logic             mismatch,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] cmp_cnt,
   output logic [CNT_W-1:0] first_err_idx,
   output logic [DW-1:0]    first_err_obs,
   output logic [DW-1:0]    first_err_exp,
   output logic             underflow,
   output logic             done,
   output logic             pass
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_nxt;

   logic [DW-1:0] mem_data [DEPTH];
   logic [FW-1:0] mem_flag [DEPTH];
   logic [DW-1:0] mem_mask [DEPTH];
   logic          mem_last [DEPTH];

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, empty, push, pop;
   logic          run_en, cmp_ev_p0, fail_p0;
   logic [DW-1:0] hd_data;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // ---- stage p0: FIFO status, handshake and combinational compare ----
   assign full          = (count == FULL_CNT);
   assign empty         = (count == '0);
   assign bus.exp_ready = !full;
   assign hd_data       = mem_data[rd_ptr];
   assign cmp_ev_p0     = run_en && bus.obs_valid;
   assign push          = bus.exp_valid && !full && !clr;
   assign pop           = cmp_ev_p0 && !empty && !clr;

   // An empty FIFO never bypasses a same-cycle push: the event is a failure.
   assign fail_p0 = empty ||
                    (|((bus.obs_data ^ hd_data) & mem_mask[rd_ptr])) ||
                    (bus.obs_flag != mem_flag[rd_ptr]);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= bus.exp_data;
         mem_flag[wr_ptr] <= bus.exp_flag;
         mem_mask[wr_ptr] <= bus.exp_mask;
         mem_last[wr_ptr] <= bus.exp_last;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // ---- FSM ----
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (arm) state_nxt = RUN;
            RUN:     if (pop && mem_last[rd_ptr]) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      run_en = (state == RUN);
      done   = (state == DONE);
      pass   = (state == DONE) && (err_cnt == '0) && !underflow;
   end

   // ---- stage p1: registered compare result and statistics ----
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mismatch      <= 1'b0;
         err_cnt       <= '0;
         cmp_cnt       <= '0;
         first_err_idx <= '0;
         first_err_obs <= '0;
         first_err_exp <= '0;
         underflow     <= 1'b0;
      end else if (clr) begin
         mismatch      <= 1'b0;
         err_cnt       <= '0;
         cmp_cnt       <= '0;
         first_err_idx <= '0;
         first_err_obs <= '0;
         first_err_exp <= '0;
         underflow     <= 1'b0;
      end else if (cmp_ev_p0) begin
         mismatch <= fail_p0;
         cmp_cnt  <= sat_inc(cmp_cnt);
         if (empty) underflow <= 1'b1;
         if (fail_p0) begin
            err_cnt <= sat_inc(err_cnt);
            // err_cnt only leaves zero on the first failure and never wraps back
            if (err_cnt == '0) begin
               first_err_idx <= cmp_cnt;
               first_err_obs <= bus.obs_data;
               first_err_exp <= empty ? '0 : hd_data;
            end
         end
      end else begin
         mismatch <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dcim_resp_checker.sv
module tb_dcim_resp_checker;
   localparam int DW    = 51;
   localparam int FW    = 1;
   localparam int DEPTH = 16;
   localparam int CNT_W = 16;
   localparam logic [DW-1:0] ONES = '1;

   logic             clk = 1'b0;
   logic             rstn = 1'b1;
   logic             clr = 1'b0;
   logic             arm = 1'b0;
   logic             mismatch;
   logic [CNT_W-1:0] err_cnt, cmp_cnt, first_err_idx;
   logic [DW-1:0]    first_err_obs, first_err_exp;
   logic             underflow, done, pass;

   int n_chk = 0;
   int n_err = 0;
   int mm_seen;

   dcim_resp_checker_if #(.DW(DW), .FW(FW)) bus ();

   dcim_resp_checker #(.DW(DW), .FW(FW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .clr           (clr),
      .arm           (arm),
      .bus           (bus),
      .mismatch      (mismatch),
      .err_cnt       (err_cnt),
      .cmp_cnt       (cmp_cnt),
      .first_err_idx (first_err_idx),
      .first_err_obs (first_err_obs),
      .first_err_exp (first_err_exp),
      .underflow     (underflow),
      .done          (done),
      .pass          (pass)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d, input logic [FW-1:0] f,
                       input logic [DW-1:0] m, input logic l);
      bus.exp_valid = 1'b1;
      bus.exp_data  = d;
      bus.exp_flag  = f;
      bus.exp_mask  = m;
      bus.exp_last  = l;
      tick();
      bus.exp_valid = 1'b0;
   endtask

   task automatic obs(input logic [DW-1:0] d, input logic [FW-1:0] f);
      bus.obs_valid = 1'b1;
      bus.obs_data  = d;
      bus.obs_flag  = f;
      tick();
      bus.obs_valid = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.exp_valid = 1'b0;
      bus.exp_data  = '0;
      bus.exp_flag  = '0;
      bus.exp_mask  = '0;
      bus.exp_last  = 1'b0;
      bus.obs_valid = 1'b0;
      bus.obs_data  = '0;
      bus.obs_flag  = '0;

      // reset state
      #2 rstn = 1'b0;
      #1;
      chk("rst_ready",    64'(bus.exp_ready), 64'd1);
      chk("rst_mismatch", 64'(mismatch),      64'd0);
      chk("rst_err",      64'(err_cnt),       64'd0);
      chk("rst_cmp",      64'(cmp_cnt),       64'd0);
      chk("rst_fidx",     64'(first_err_idx), 64'd0);
      chk("rst_fobs",     64'(first_err_obs), 64'd0);
      chk("rst_fexp",     64'(first_err_exp), 64'd0);
      chk("rst_under",    64'(underflow),     64'd0);
      chk("rst_done",     64'(done),          64'd0);
      chk("rst_pass",     64'(pass),          64'd0);
      @(negedge clk);
      rstn = 1'b1;
      tick();

      // 1: clean stream
      push(DW'(1), 1'b0, ONES, 1'b0);
      push(DW'(2), 1'b0, ONES, 1'b0);
      push(DW'(3), 1'b1, ONES, 1'b1);
      do_arm();
      mm_seen = 0;
      obs(DW'(1), 1'b0); mm_seen += int'(mismatch);
      chk("clean_done_early", 64'(done), 64'd0);
      obs(DW'(2), 1'b0); mm_seen += int'(mismatch);
      obs(DW'(3), 1'b1); mm_seen += int'(mismatch);
      chk("clean_mm",   64'(mm_seen), 64'd0);
      chk("clean_err",  64'(err_cnt), 64'd0);
      chk("clean_cmp",  64'(cmp_cnt), 64'd3);
      chk("clean_done", 64'(done),    64'd1);
      chk("clean_pass", 64'(pass),    64'd1);
      do_clr();
      chk("clr_done", 64'(done),    64'd0);
      chk("clr_cmp",  64'(cmp_cnt), 64'd0);

      // 2a: difference outside the mask
      push(DW'(16'h00FF), 1'b0, DW'(16'h000F), 1'b1);
      do_arm();
      obs(DW'(16'h0AFF), 1'b0);
      chk("mask_ok_mm",   64'(mismatch), 64'd0);
      chk("mask_ok_pass", 64'(pass),     64'd1);
      do_clr();

      // 2b: difference inside the mask
      push(DW'(16'h00FF), 1'b0, DW'(16'h0F00), 1'b1);
      do_arm();
      obs(DW'(16'h0AFF), 1'b0);
      chk("mask_bad_mm",   64'(mismatch),      64'd1);
      chk("mask_bad_err",  64'(err_cnt),       64'd1);
      chk("mask_bad_fidx", 64'(first_err_idx), 64'd0);
      chk("mask_bad_fobs", 64'(first_err_obs), 64'h0AFF);
      chk("mask_bad_fexp", 64'(first_err_exp), 64'h00FF);
      chk("mask_bad_done", 64'(done),          64'd1);
      chk("mask_bad_pass", 64'(pass),          64'd0);
      tick();
      chk("mask_bad_pulse", 64'(mismatch), 64'd0);
      do_clr();

      // 3: flag mismatch with all-zero mask
      push(DW'(16'h0055), 1'b1, '0, 1'b1);
      do_arm();
      obs(DW'(16'h0055), 1'b0);
      chk("flag_mm",   64'(mismatch), 64'd1);
      chk("flag_err",  64'(err_cnt),  64'd1);
      chk("flag_pass", 64'(pass),     64'd0);
      do_clr();

      // 4: underflow, with a same-cycle push that must not be bypassed
      do_arm();
      bus.exp_valid = 1'b1;
      bus.exp_data  = DW'(7);
      bus.exp_flag  = 1'b0;
      bus.exp_mask  = ONES;
      bus.exp_last  = 1'b1;
      obs(DW'(16'h0123), 1'b0);
      bus.exp_valid = 1'b0;
      chk("uf_flag", 64'(underflow),     64'd1);
      chk("uf_mm",   64'(mismatch),      64'd1);
      chk("uf_err",  64'(err_cnt),       64'd1);
      chk("uf_cmp",  64'(cmp_cnt),       64'd1);
      chk("uf_fobs", 64'(first_err_obs), 64'h0123);
      chk("uf_fexp", 64'(first_err_exp), 64'd0);
      chk("uf_done", 64'(done),          64'd0);
      obs(DW'(7), 1'b0);
      chk("uf2_mm",   64'(mismatch), 64'd0);
      chk("uf2_cmp",  64'(cmp_cnt),  64'd2);
      chk("uf2_err",  64'(err_cnt),  64'd1);
      chk("uf2_done", 64'(done),     64'd1);
      chk("uf2_pass", 64'(pass),     64'd0);
      do_clr();
      chk("uf_clr", 64'(underflow), 64'd0);

      // 5: fill to full, dropped extra push, streaming across pointer wrap
      for (int w = 0; w < DEPTH; w++) push(DW'(32'h1000 + w), 1'b0, ONES, 1'b0);
      chk("full_ready", 64'(bus.exp_ready), 64'd0);
      push(DW'(32'hDEAD), 1'b0, ONES, 1'b1);
      chk("full_ready2", 64'(bus.exp_ready), 64'd0);
      do_arm();
      mm_seen = 0;
      for (int k = 0; k < 3*DEPTH; k++) begin
         bus.obs_valid = 1'b1;
         bus.obs_data  = DW'(32'h1000 + k);
         bus.obs_flag  = 1'b0;
         bus.exp_valid = (k >= 1);
         bus.exp_data  = DW'(32'h1000 + DEPTH - 1 + k);
         bus.exp_flag  = 1'b0;
         bus.exp_mask  = ONES;
         bus.exp_last  = (DEPTH - 1 + k == 3*DEPTH - 1);
         tick();
         mm_seen += int'(mismatch);
      end
      bus.obs_valid = 1'b0;
      bus.exp_valid = 1'b0;
      chk("wrap_mm",    64'(mm_seen),       64'd0);
      chk("wrap_cmp",   64'(cmp_cnt),       64'(3*DEPTH));
      chk("wrap_err",   64'(err_cnt),       64'd0);
      chk("wrap_pass",  64'(pass),          64'd1);
      chk("wrap_ready", 64'(bus.exp_ready), 64'd1);
      do_clr();

      // 6a: clr mid-run, also overriding arm and a bad sample
      for (int w = 1; w <= 5; w++) push(DW'(w), 1'b0, ONES, (w == 5));
      do_arm();
      obs(DW'(1), 1'b0);
      obs(DW'(2), 1'b0);
      clr = 1'b1;
      arm = 1'b1;
      obs(DW'(16'hBAD), 1'b0);
      clr = 1'b0;
      arm = 1'b0;
      chk("mclr_cmp",   64'(cmp_cnt),       64'd0);
      chk("mclr_err",   64'(err_cnt),       64'd0);
      chk("mclr_mm",    64'(mismatch),      64'd0);
      chk("mclr_ready", 64'(bus.exp_ready), 64'd1);
      chk("mclr_done",  64'(done),          64'd0);
      push(DW'(16'h21), 1'b0, ONES, 1'b0);
      push(DW'(16'h22), 1'b0, ONES, 1'b1);
      do_arm();
      obs(DW'(16'h21), 1'b0);
      obs(DW'(16'h22), 1'b0);
      chk("mclr_fresh_cmp",  64'(cmp_cnt), 64'd2);
      chk("mclr_fresh_pass", 64'(pass),    64'd1);
      do_clr();

      // 6b: asynchronous reset mid-run
      for (int w = 1; w <= 5; w++) push(DW'(16'h30 + w), 1'b0, ONES, (w == 5));
      do_arm();
      obs(DW'(16'h31), 1'b0);
      obs(DW'(16'h32), 1'b0);
      chk("arst_pre_cmp", 64'(cmp_cnt), 64'd2);
      #3 rstn = 1'b0;
      #1;
      chk("arst_cmp",   64'(cmp_cnt),       64'd0);
      chk("arst_ready", 64'(bus.exp_ready), 64'd1);
      chk("arst_done",  64'(done),          64'd0);
      #2 rstn = 1'b1;
      tick();
      push(DW'(16'h41), 1'b0, ONES, 1'b1);
      do_arm();
      obs(DW'(16'h41), 1'b0);
      chk("arst_fresh_cmp",  64'(cmp_cnt), 64'd1);
      chk("arst_fresh_pass", 64'(pass),    64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/dcim_resp_checker.md
Name: dcim_resp_checker

Overview:
- Synthesizable, parametrised response checker for the DCIM macro output stream (nout/st).
- Expected words are pushed into an internal FIFO over a valid/ready port.
- Each observed DUT sample pops one expected word and is compared under a per-bit mask; the block keeps error statistics and captures the first mismatch.
- Used in FPGA bring-up and on-chip self-test alongside the top-level DCIM macro.

Parameters:
DW, 51, observed data width (matches nout)
FW, 1, observed flag width (matches st)
DEPTH, 16, expected-word FIFO depth, power of two, >=2
CNT_W, 16, width of the error and compare counters

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
clr  in  1  synchronous clear: flush FIFO, zero stats, go to IDLE
arm  in  1  start-of-check pulse, honoured only in IDLE
exp_valid  in  1  expected word valid
exp_ready  out  1  FIFO can accept a word (= !full)
exp_data  in  DW  expected data
exp_flag  in  FW  expected flag
exp_mask  in  DW  1 = compare this data bit
exp_last  in  1  marks the final expected word of a check
obs_valid  in  1  DUT sample valid
obs_data  in  DW  observed data (nout)
obs_flag  in  FW  observed flag (st)
mismatch  out  1  one-cycle pulse per failing compare
err_cnt  out  CNT_W  failing compares, saturating
cmp_cnt  out  CNT_W  total compares, saturating
first_err_idx  out  CNT_W  cmp_cnt value of the first failure
first_err_obs  out  DW  observed data at the first failure
first_err_exp  out  DW  expected data at the first failure
underflow  out  1  sticky: obs_valid arrived while the FIFO was empty
done  out  1  high in DONE
pass  out  1  high in DONE when err_cnt==0 and !underflow

Behaviour:
- Reset (rstn low, asynchronous):
  - FSM goes to IDLE and the FIFO is emptied.
  - All outputs are 0, except exp_ready=1.
- clr has priority over every other input. It has the same effect as reset but is synchronous.
- FIFO:
  - A push occurs when exp_valid && exp_ready.
  - The entry is {data, flag, mask, last}.
  - Pushing is allowed in every state.
  - Full: exp_ready=0 and pushes are ignored.
  - Pointers wrap modulo DEPTH. Occupancy is tracked with a DEPTH+1-state count.
  - Simultaneous push and pop on a full FIFO: the pop frees a slot, but exp_ready is still 0 that cycle, so there is no push.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on arm. obs_valid is ignored in IDLE.
  - RUN: each obs_valid is one compare event.
  - RUN -> DONE on the cycle after a compare whose popped entry has last=1.
  - DONE holds until clr or reset. obs_valid and arm are ignored in DONE.
- Compare event in RUN with FIFO non-empty:
  - Pop the head entry.
  - fail = |((obs_data ^ exp_data) & exp_mask) || (obs_flag != exp_flag). The flag is never masked.
  - Registered result: mismatch, err_cnt, cmp_cnt and the capture registers update at the clock edge after obs_valid, so the latency is 1 cycle.
- Compare event in RUN with FIFO empty:
  - No pop. The head is not bypassed, even if a push happens the same cycle.
  - underflow is set (sticky).
  - The event counts as a failure: err_cnt and cmp_cnt increment and mismatch pulses.
  - Capture registers store obs_data and 0 for expected.
- first_err_* load only on the first failure after reset or clr.
- Counters saturate at 2^CNT_W-1. Saturation does not wrap and does not affect pass.
- cmp_cnt and first_err_idx use pre-increment numbering, so the first compare has index 0.
- pass and done are combinational from state and registers. pass is 0 outside DONE.
- Entries left in the FIFO at DONE are retained and not checked. They are flushed by clr.

Test Plan:
1. Clean stream: push 3 words {0x1,0,all-ones,0}, {0x2,0,all-ones,0}, {0x3,1,all-ones,1}. Arm, then drive 3 matching obs → err_cnt=0, cmp_cnt=3, done=1, pass=1, mismatch never high.
2. Masked miscompare: expected 0x00FF with mask 0x000F, observed 0x0AFF → no failure. Same observation with mask 0x0F00 → mismatch pulse 1 cycle later, err_cnt=1, first_err_idx=0, first_err_obs=0x0AFF, first_err_exp=0x00FF, pass=0 at DONE.
3. Flag mismatch: data equal, exp_flag=1, obs_flag=0 → failure counted, even with mask all-zero.
4. Underflow: arm with an empty FIFO, obs_valid once → underflow=1, err_cnt=1, cmp_cnt=1. Then push a last word and compare with a match → DONE with pass=0.
5. Full/wrap: push DEPTH words → exp_ready=0 and the extra push is dropped. Pop/push 3*DEPTH words streaming → all compare correctly across pointer wrap.
6. Reset/clear mid-run: after 2 of 5 compares, assert clr for 1 cycle (and separately drop rstn asynchronously) → IDLE, FIFO empty, all counters 0, exp_ready=1 immediately. A fresh arm-and-check then passes.
